// File: rtl/pwm_led_pkg.sv
// Shared constants and helpers for the multi-channel PWM LED driver.
// Holds the mode encoding and the full-scale duty derivation.
package pwm_led_pkg;

    localparam logic MODE_JUMP = 1'b0;
    localparam logic MODE_FADE = 1'b1;

    // Full-scale duty: a target of all ones means "always on".
    function automatic int unsigned max_duty(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_led_channel.sv
// One LED channel: holds target and active duty, ramps or jumps at period
// boundaries, and compares active duty against the shared counter.
module pwm_led_channel
    import pwm_led_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty,
    input  logic             load,
    input  logic             fade_en,
    input  logic             boundary,
    input  logic [WIDTH-1:0] cnt_nxt,
    output logic             led,
    output logic             busy
);

    localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(RAMP_STEP);

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] active_nxt;
    logic [WIDTH-1:0] ramp;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_gap;

    // One extra bit so stepping can saturate at the target instead of wrapping.
    assign up_sum   = {1'b0, active} + STEP;
    assign down_gap = {1'b0, active} - {1'b0, target};

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        ramp       = active;
        active_nxt = active;
        if (active < target) begin
            ramp = (up_sum >= {1'b0, target}) ? target : up_sum[WIDTH-1:0];
        end else if (active > target) begin
            ramp = (down_gap <= STEP) ? target : active - STEP[WIDTH-1:0];
        end
        if (boundary) begin
            active_nxt = (fade_en == MODE_FADE) ? ramp : target;
        end
    end

    // NOTE: every register, target and active included, is cleared by the async reset, so no ramp state survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
            active <= '0;
            led    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (load) begin
                target <= duty;
            end
            active <= active_nxt;
            led    <= (active_nxt > cnt_nxt);
        end
    end

    assign busy = (active != target);

endmodule

// File: rtl/pwm_led_multi.sv
// Multi-channel PWM LED driver: shared prescaler and period counter feeding
// N_CH independent channels with optional duty fading.
module pwm_led_multi
    import pwm_led_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int RAMP_STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] duty_in,
    input  logic [N_CH-1:0]       load,
    input  logic [N_CH-1:0]       fade_en,
    output logic [N_CH-1:0]       LED,
    output logic [N_CH-1:0]       busy,
    output logic                  period_start
);

    localparam int unsigned      MAX      = max_duty(WIDTH);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MAX - 1);

    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             primed;
    logic             tick;
    logic             boundary;

    assign tick = (pre == PRE_LAST);

    // The first tick after reset opens a period, so a period_start follows PRESCALE clk after release.
    assign boundary = tick && (!primed || (cnt == CNT_LAST));

    always_comb begin
        cnt_nxt = cnt;
        if (tick) begin
            cnt_nxt = boundary ? '0 : cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre          <= '0;
            cnt          <= '0;
            primed       <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre          <= tick ? '0 : pre + PW'(1);
            cnt          <= cnt_nxt;
            period_start <= boundary;
            if (tick) begin
                primed <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_led_channel #(
            .WIDTH    (WIDTH),
            .RAMP_STEP(RAMP_STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .duty    (duty_in[k*WIDTH +: WIDTH]),
            .load    (load[k]),
            .fade_en (fade_en[k]),
            .boundary(boundary),
            .cnt_nxt (cnt_nxt),
            .led     (LED[k]),
            .busy    (busy[k])
        );
    end

endmodule

// File: tb/tb_pwm_led_multi.sv
// Bench for pwm_led_multi: a default build and a PRESCALE=3/RAMP_STEP=4 build,
// with per-period LED high counts and busy scored against a queue of expectations.
module tb_pwm_led_multi;

    typedef struct {
        int   d;
        int   period;
        int   ch;
        int   high;
        logic busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst3_n = 1'b0;
    logic [31:0] duty1 = '0, duty3 = '0;
    logic [3:0]  load1 = '0, load3 = '0;
    logic [3:0]  fade1 = '0, fade3 = '0;
    logic [3:0]  led1, led3, busy1, busy3;
    logic        ps1, ps3;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    int       mp[2];
    int       len[2];
    int       highs[2][4];
    logic [3:0] busy0[2];

    always #5 clk = ~clk;

    pwm_led_multi dut (
        .clk(clk), .rst_n(rst_n), .duty_in(duty1), .load(load1), .fade_en(fade1),
        .LED(led1), .busy(busy1), .period_start(ps1)
    );

    pwm_led_multi #(.N_CH(4), .WIDTH(8), .PRESCALE(3), .RAMP_STEP(4)) dut3 (
        .clk(clk), .rst_n(rst3_n), .duty_in(duty3), .load(load3), .fade_en(fade3),
        .LED(led3), .busy(busy3), .period_start(ps3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ps_of(input int d);
        return (d == 0) ? ps1 : ps3;
    endfunction

    function automatic logic rst_of(input int d);
        return (d == 0) ? rst_n : rst3_n;
    endfunction

    function automatic logic [3:0] led_of(input int d);
        return (d == 0) ? led1 : led3;
    endfunction

    function automatic logic [3:0] busy_of(input int d);
        return (d == 0) ? busy1 : busy3;
    endfunction

    task automatic push(input int d, input int period, input int ch, input int high, input logic busy);
        sb.push_back('{d, period, ch, high, busy});
    endtask

    task automatic pulse(input int d, input logic [3:0] mask, input logic [31:0] duty);
        if (d == 0) begin duty1 = duty; load1 = mask; end
        else        begin duty3 = duty; load3 = mask; end
        @(negedge clk);
        if (d == 0) load1 = '0;
        else        load3 = '0;
    endtask

    task automatic wait_ps(input int d, inout int sp, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ps_of(d) && n < 2000);
        check($sformatf("dut%0d period_start seen", d), 32'(ps_of(d)), 32'd1);
        sp++;
    endtask

    // Closes period mp[d]: checks its length and every expectation tagged with it.
    task automatic finalize(input int d);
        int i;
        check($sformatf("dut%0d p%0d length", d, mp[d]), len[d], (d == 0) ? 255 : 765);
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].d == d && sb[i].period == mp[d]) begin
                check($sformatf("dut%0d p%0d ch%0d led_high", d, mp[d], sb[i].ch),
                      highs[d][sb[i].ch], sb[i].high);
                check($sformatf("dut%0d p%0d ch%0d busy_at_start", d, mp[d], sb[i].ch),
                      32'(busy0[d][sb[i].ch]), 32'(sb[i].busy));
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_of(d)) begin
                mp[d]  = 0;
                len[d] = 0;
            end else begin
                if (ps_of(d)) begin
                    if (mp[d] > 0) finalize(d);
                    mp[d]++;
                    len[d]   = 0;
                    busy0[d] = busy_of(d);
                    for (int c = 0; c < 4; c++) highs[d][c] = 0;
                end
                if (mp[d] > 0) begin
                    len[d]++;
                    for (int c = 0; c < 4; c++) highs[d][c] += int'(led_of(d)[c]);
                end
            end
        end
    end

    task automatic dut1_seq();
        int sp = 0;
        int n;
        wait_ps(0, sp, n);
        check("dut0 first period_start latency", n, 1);
        fade1 = 4'b1000;
        pulse(0, 4'b1111, {8'd10, 8'd255, 8'd0, 8'd128});
        for (int c = 0; c < 4; c++) push(0, 1, c, 0, 1'b0);
        for (int p = 2; p <= 4; p++) begin
            push(0, p, 0, 128, 1'b0);
            push(0, p, 1, 0, 1'b0);
            push(0, p, 2, 255, 1'b0);
        end
        for (int k = 1; k <= 11; k++) push(0, k + 1, 3, (k > 10) ? 10 : k, k < 10);
        repeat (11) wait_ps(0, sp, n);

        // Load lands on the boundary edge itself (last clk of period 12).
        repeat (254) @(negedge clk);
        pulse(0, 4'b0001, {24'd0, 8'd40});
        sp++;
        push(0, 13, 0, 128, 1'b1);
        push(0, 14, 0, 40, 1'b0);
        wait_ps(0, sp, n);

        // Fade ch3 down from 10 toward 0, then reset when active is 5.
        pulse(0, 4'b1000, 32'd0);
        push(0, 14, 3, 10, 1'b0);
        for (int k = 1; k <= 4; k++) push(0, 14 + k, 3, 10 - k, 1'b1);
        repeat (5) wait_ps(0, sp, n);
        #2 rst_n = 1'b0;
        #1;
        check("dut0 LED during reset", 32'(led1), 32'd0);
        check("dut0 busy during reset", 32'(busy1), 32'd0);
        check("dut0 period_start during reset", 32'(ps1), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sp = 0;
        wait_ps(0, sp, n);
        check("dut0 period_start latency after reset", n, 1);
        pulse(0, 4'b1000, {8'd3, 24'd0});
        for (int c = 0; c < 4; c++) push(0, 1, c, 0, 1'b0);
        for (int c = 0; c < 3; c++) push(0, 2, c, 0, 1'b0);
        push(0, 2, 3, 1, 1'b1);
        push(0, 3, 3, 2, 1'b1);
        push(0, 4, 3, 3, 1'b0);
        repeat (4) wait_ps(0, sp, n);
    endtask

    task automatic dut3_seq();
        int sp = 0;
        int n;
        wait_ps(1, sp, n);
        check("dut1 first period_start latency", n, 3);
        fade3 = 4'b1000;
        pulse(1, 4'b1011, {8'd10, 8'd0, 8'd255, 8'd128});
        for (int c = 0; c < 4; c++) push(1, 1, c, 0, 1'b0);
        push(1, 2, 0, 384, 1'b0);
        push(1, 2, 1, 765, 1'b0);
        push(1, 2, 2, 0, 1'b0);
        push(1, 2, 3, 12, 1'b1);
        push(1, 3, 3, 24, 1'b1);
        push(1, 4, 3, 30, 1'b0);
        repeat (3) wait_ps(1, sp, n);

        // New target 30 while fading; fade_en drops mid-period 5 and is seen at that boundary.
        pulse(1, 4'b1000, {8'd30, 24'd0});
        push(1, 5, 3, 42, 1'b1);
        push(1, 6, 3, 90, 1'b0);
        wait_ps(1, sp, n);
        repeat (100) @(negedge clk);
        fade3 = 4'b0000;
        repeat (2) wait_ps(1, sp, n);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("dut0 LED in reset", 32'(led1), 32'd0);
        check("dut0 busy in reset", 32'(busy1), 32'd0);
        check("dut0 period_start in reset", 32'(ps1), 32'd0);
        check("dut1 LED in reset", 32'(led3), 32'd0);
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        fork
            dut1_seq();
            dut3_seq();
        join
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_led_multi.md
PWM_LED_MULTI -- requirements
Module: pwm_led_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent LED channels.
REQ-002 SHALL have parameter WIDTH, default 8: duty/counter resolution in bits.
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per PWM counter tick (>=1).
REQ-004 SHALL have parameter RAMP_STEP, default 1: duty increment/decrement per period in fade mode.
REQ-005 SHALL have port clk, input, 1: single system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port duty_in, input, N_CH*WIDTH: requested duty per channel; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port load, input, N_CH: per-channel one-cycle strobe capturing that channel's duty_in slice as its target.
REQ-009 SHALL have port fade_en, input, N_CH: per-channel mode; 1 = ramp toward target, 0 = jump to target.
REQ-010 SHALL have port LED, output, N_CH: PWM output per channel.
REQ-011 SHALL have port busy, output, N_CH: high while a channel's active duty differs from its target.
REQ-012 SHALL have port period_start, output, 1: one-cycle pulse on the first clk of each PWM period.

Function
REQ-013 SHALL run a prescaler counting 0..PRESCALE-1, producing a tick on the clk where it wraps to 0.
REQ-014 SHALL advance one shared PWM counter cnt on each tick, from 0 to MAX-1 with MAX = 2^WIDTH-1, then wrap to 0; period = MAX*PRESCALE clk.
REQ-015 SHALL drive LED[k] = (active[k] > cnt), registered; active 0 gives constant low, active MAX gives constant high.
REQ-016 SHALL capture the target on load[k]; the last load before a boundary wins; load does not alter active mid-period.
REQ-017 SHALL update active[k] only at the period boundary (cnt wrap to 0 on tick), so no period is truncated or glitched.
REQ-018 SHALL, at a boundary with fade_en[k]=0, set active[k] = target[k].
REQ-019 SHALL, at a boundary with fade_en[k]=1, move active[k] toward target[k] by RAMP_STEP, saturating exactly at target (no overshoot, no wrap below 0 or above MAX).
REQ-020 SHALL treat a target of 2^WIDTH-1 as MAX (full on); all duty arithmetic is unsigned, WIDTH+1 bits internally for saturation.
REQ-021 SHALL, if load and a boundary coincide on one clk, apply the old target at that boundary and the new one from the next boundary.
REQ-022 SHALL sample fade_en[k] at the boundary; changing it mid-ramp takes effect at the next boundary.
REQ-023 SHALL drive busy[k] = (active[k] != target[k]), combinational from registers.
REQ-024 SHALL assert period_start for exactly one clk, when cnt becomes 0.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear prescaler, cnt, all target and active registers, LED, and period_start to 0; busy consequently reads 0.
REQ-026 SHALL, after rst_n deassertion, assert the first period_start PRESCALE clk later (first wrap), and not before.
REQ-027 SHALL, on reset mid-ramp, abandon the ramp; no state survives reset.

Structure
REQ-028 SHALL place the MAX derivation function and mode encoding constants in package pwm_led_pkg.
REQ-029 SHALL implement per-channel target/active/LED logic in sub-module pwm_led_channel, generated N_CH times; prescaler and cnt stay shared in pwm_led_multi.
REQ-030 SHALL fit within 120-400 lines of RTL total.

Verification (N_CH=4, WIDTH=8, PRESCALE=1, RAMP_STEP=1 unless stated)
REQ-031 SHALL cover: load ch0=128, fade_en=0 -> from next period, LED[0] high 128 of every 255 clk; busy[0] clears at that boundary.
REQ-032 SHALL cover: ch1 load 0 and ch2 load 255 -> LED[1] constant 0, LED[2] constant 1 across 3 full periods.
REQ-033 SHALL cover: ch3 fade_en=1, active 0, load 10 -> active 1,2,...,10 over 10 consecutive periods; busy[3] falls at the 10th boundary; RAMP_STEP=4 build -> 4,8,10.
REQ-034 SHALL cover: load asserted on the boundary clk -> old target applied that period, new target next period.
REQ-035 SHALL cover: PRESCALE=3 -> period_start every 765 clk; LED[0] high 384 clk for duty 128.
REQ-036 SHALL cover: rst_n low mid-ramp (active=5) -> all LED/busy/period_start 0 immediately, without a clk edge; ramp restarts from 0 after new load.
